// File: rtl/modarith_pkg.sv
// rtl/modarith_pkg.sv - opcodes and default modulus for the GF(Q) add/sub pipeline
package modarith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_DBL = 2'b10,
        OP_NEG = 2'b11
    } op_e;

    localparam int DEFAULT_WIDTH = 255;

    // 2**255 - 19, written as all-ones minus 18 so it fits exactly in 255 bits
    localparam logic [254:0] Q_25519 = {255{1'b1}} - 255'd18;

endpackage

// File: rtl/modarith_addsub_core.sv
// rtl/modarith_addsub_core.sv - combinational first-stage arithmetic: raw and corrected candidates
module modarith_addsub_core
    import modarith_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] Q     = Q_25519
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] raw_lo,
    output logic             raw_neg,
    output logic [WIDTH-1:0] alt_lo,
    output logic             alt_neg,
    output logic             reduce
);

    localparam int EW = WIDTH + 2;

    logic [EW-1:0] a;
    logic [EW-1:0] b;
    logic [EW-1:0] qe;
    logic [EW-1:0] raw;
    logic [EW-1:0] alt;

    // reduce=1: result may be in [Q, 2Q) and needs -Q; reduce=0: result may be negative and needs +Q.
    // NEG (Q-X) lands in [1, Q], so it shares the reduce path and maps X=0 to 0.
    always_comb begin
        qe     = {2'b00, Q};
        a      = {2'b00, x};
        b      = {2'b00, y};
        reduce = 1'b1;
        raw    = a + b;
        case (op)
            OP_ADD: raw = a + b;
            OP_SUB: begin
                raw    = a - b;
                reduce = 1'b0;
            end
            OP_DBL: raw = a + a;
            OP_NEG: raw = qe - a;
            default: raw = a + b;
        endcase
        alt = reduce ? (raw - qe) : (raw + qe);
    end

    assign raw_lo  = raw[WIDTH-1:0];
    assign raw_neg = raw[EW-1];
    assign alt_lo  = alt[WIDTH-1:0];
    assign alt_neg = alt[EW-1];

    logic unused_carry;
    assign unused_carry = raw[WIDTH] ^ alt[WIDTH];

endmodule

// File: rtl/modarith_addsub_pipe.sv
// rtl/modarith_addsub_pipe.sv - 2-stage modular add/sub/dbl/neg; MODARITH_RANGE_CHECK_EN enables o_err
module modarith_addsub_pipe
    import modarith_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] Q     = Q_25519,
    parameter int               TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_err
);

    op_e              in_op;
    logic [WIDTH-1:0] c_raw_lo;
    logic             c_raw_neg;
    logic [WIDTH-1:0] c_alt_lo;
    logic             c_alt_neg;
    logic             c_reduce;
    logic             in_err;

    logic             s1_v;
    logic [WIDTH-1:0] s1_raw_lo;
    logic             s1_raw_neg;
    logic [WIDTH-1:0] s1_alt_lo;
    logic             s1_alt_neg;
    logic             s1_reduce;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_err;

    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] s2_sel;

    assign in_op = op_e'(i_op);

    modarith_addsub_core #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_core (
        .op      (in_op),
        .x       (i_x),
        .y       (i_y),
        .raw_lo  (c_raw_lo),
        .raw_neg (c_raw_neg),
        .alt_lo  (c_alt_lo),
        .alt_neg (c_alt_neg),
        .reduce  (c_reduce)
    );

`ifdef MODARITH_RANGE_CHECK_EN
    assign in_err = (i_x >= Q) || (((in_op == OP_ADD) || (in_op == OP_SUB)) && (i_y >= Q));
`else
    assign in_err = 1'b0;
`endif

    // No skid buffer: a drain at the output frees a slot for an accept in the same cycle.
    assign s2_adv  = !o_valid || i_ready;
    assign s1_adv  = !s1_v || s2_adv;
    assign o_ready = s1_adv;

    assign s2_sel = s1_reduce ? (s1_alt_neg ? s1_raw_lo : s1_alt_lo)
                              : (s1_raw_neg ? s1_alt_lo : s1_raw_lo);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v       <= 1'b0;
            s1_raw_lo  <= '0;
            s1_raw_neg <= 1'b0;
            s1_alt_lo  <= '0;
            s1_alt_neg <= 1'b0;
            s1_reduce  <= 1'b0;
            s1_tag     <= '0;
            s1_err     <= 1'b0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_tag      <= '0;
            o_err      <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_v <= i_valid;
                if (i_valid) begin
                    s1_raw_lo  <= c_raw_lo;
                    s1_raw_neg <= c_raw_neg;
                    s1_alt_lo  <= c_alt_lo;
                    s1_alt_neg <= c_alt_neg;
                    s1_reduce  <= c_reduce;
                    s1_tag     <= i_tag;
                    s1_err     <= in_err;
                end
            end
            if (s2_adv) begin
                o_valid <= s1_v;
                if (s1_v) begin
                    o_result <= s2_sel;
                    o_tag    <= s1_tag;
                    o_err    <= s1_err;
                end
            end
        end
    end

endmodule
